// File: rtl/car_sprite_mover_if.sv
// car_sprite_mover_if: pixel-stream and control bundle for one car sprite engine.
//   en           step request (master -> engine)
//   colour       car draw colour (master -> engine)
//   plot,x,y     pixel write strobe and address toward the VGA plot arbiter
//   colour_out   pixel colour (0 while erasing)
//   x_pos        current origin x, for collision logic
//   moving_right current direction
//   busy, done   step in progress / one-cycle completion pulse
interface car_sprite_mover_if;
  logic       en;
  logic [2:0] colour;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour_out;
  logic [7:0] x_pos;
  logic       moving_right;
  logic       busy;
  logic       done;

  modport master (
    output en, colour,
    input  plot, x, y, colour_out, x_pos, moving_right, busy, done
  );

  modport slave (
    input  en, colour,
    output plot, x, y, colour_out, x_pos, moving_right, busy, done
  );
endinterface

// File: rtl/car_sprite_mover.sv
// car_sprite_mover: moves one car sprite along a lane of the 160x120 playfield.
// Each accepted step erases the car at its old origin, advances the origin
// (wrap or bounce at the bounds), redraws it, then holds for a frame delay.
//   clk     system clock, rising edge
//   resetn  asynchronous active-low reset
//   bus     car_sprite_mover_if.slave (en/colour in; pixel stream, status out)
module car_sprite_mover #(
  parameter int CAR_W        = 8,
  parameter int CAR_H        = 4,
  parameter int X_START      = 62,
  parameter int Y_LANE       = 75,
  parameter int X_MIN        = 26,
  parameter int X_MAX        = 127,
  parameter int STEP         = 1,
  parameter bit DIR_RIGHT    = 1'b1,
  parameter bit BOUNCE       = 1'b0,
  parameter int DELAY_CYCLES = 83,
  parameter int HOLD_FRAMES  = 5
) (
  input logic               clk,
  input logic               resetn,
  car_sprite_mover_if.slave bus
);

  localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam int FW = (HOLD_FRAMES  > 1) ? $clog2(HOLD_FRAMES)  : 1;

  typedef enum logic [2:0] {S_IDLE, S_ERASE, S_MOVE, S_DRAW, S_HOLD} state_e;

  state_e        state_q;
  logic [3:0]    col_q;
  logic [2:0]    row_q;
  logic [7:0]    org_q;
  logic          dir_q;
  logic [DW-1:0] dly_q;
  logic [FW-1:0] frm_q;
  logic          plot_q;
  logic          done_q;
  logic [7:0]    x_q;
  logic [6:0]    y_q;

  // Scan position bookkeeping (column offset fastest).
  logic       last_col, last_row, scanning;
  logic [3:0] col_nx;
  logic [2:0] row_nx;

  assign last_col = (col_q == 4'(CAR_W - 1));
  assign last_row = (row_q == 3'(CAR_H - 1));
  assign scanning = (state_q == S_ERASE) || (state_q == S_DRAW);
  assign col_nx   = last_col ? 4'd0 : col_q + 4'd1;
  assign row_nx   = last_col ? row_q + 3'd1 : row_q;

  // Origin update applied on leaving MOVE; 9-bit so the compare never wraps.
  logic [7:0] org_d;
  logic       dir_d;
  logic [8:0] org9, sum9;

  assign org9 = {1'b0, org_q};
  assign sum9 = org9 + 9'(STEP);

  always_comb begin
    org_d = org_q;
    dir_d = dir_q;
    if (dir_q) begin
      if (sum9 <= 9'(X_MAX)) begin
        org_d = sum9[7:0];
      end else if (!BOUNCE) begin
        org_d = 8'(X_MIN);
      end else begin
        org_d = 8'(X_MAX);
        dir_d = 1'b0;
      end
    end else begin
      if (org9 >= 9'(X_MIN) + 9'(STEP)) begin
        org_d = org_q - 8'(STEP);
      end else if (!BOUNCE) begin
        org_d = 8'(X_MAX);
      end else begin
        org_d = 8'(X_MIN);
        dir_d = 1'b1;
      end
    end
  end

  // Pixel presented in the *next* cycle. Outputs are registered, so the FSM
  // loads the pixel one edge ahead: scan start uses (0,0), in-scan uses the
  // successor, and leaving MOVE already uses the updated origin.
  logic [7:0] scan_org;
  logic [3:0] scan_col;
  logic [2:0] scan_row;
  logic [8:0] pix_x_d;
  logic [7:0] pix_y_d;
  logic       pix_vis_d;

  assign scan_org  = (state_q == S_MOVE) ? org_d : org_q;
  assign scan_col  = scanning ? col_nx : 4'd0;
  assign scan_row  = scanning ? row_nx : 3'd0;
  assign pix_x_d   = {1'b0, scan_org} + 9'(scan_col);
  assign pix_y_d   = 8'(Y_LANE) + 8'(scan_row);
  assign pix_vis_d = (pix_x_d < 9'd160) && (pix_y_d < 8'd120);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      org_q   <= 8'(X_START);
      dir_q   <= DIR_RIGHT;
      dly_q   <= '0;
      frm_q   <= '0;
      plot_q  <= 1'b0;
      done_q  <= 1'b0;
      x_q     <= 8'(X_START);
      y_q     <= 7'(Y_LANE);
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.en) begin
            state_q <= S_ERASE;
            col_q   <= '0;
            row_q   <= '0;
            plot_q  <= pix_vis_d;
            x_q     <= pix_x_d[7:0];
            y_q     <= pix_y_d[6:0];
          end
        end
        S_ERASE, S_DRAW: begin
          if (last_col && last_row) begin
            plot_q <= 1'b0;
            if (state_q == S_ERASE) begin
              state_q <= S_MOVE;
            end else begin
              state_q <= S_HOLD;
              dly_q   <= '0;
              frm_q   <= '0;
            end
          end else begin
            col_q  <= col_nx;
            row_q  <= row_nx;
            plot_q <= pix_vis_d;
            x_q    <= pix_x_d[7:0];
            y_q    <= pix_y_d[6:0];
          end
        end
        S_MOVE: begin
          state_q <= S_DRAW;
          org_q   <= org_d;
          dir_q   <= dir_d;
          col_q   <= '0;
          row_q   <= '0;
          plot_q  <= pix_vis_d;
          x_q     <= pix_x_d[7:0];
          y_q     <= pix_y_d[6:0];
        end
        S_HOLD: begin
          if (dly_q == DW'(DELAY_CYCLES - 1)) begin
            dly_q <= '0;
            if (frm_q == FW'(HOLD_FRAMES - 1)) begin
              frm_q   <= '0;
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end else begin
              frm_q <= frm_q + 1'b1;
            end
          end else begin
            dly_q <= dly_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.plot         = plot_q;
  assign bus.x            = x_q;
  assign bus.y            = y_q;
  // Colour is passed through live while drawing; erase always writes black.
  assign bus.colour_out   = (state_q == S_DRAW) ? bus.colour : 3'd0;
  assign bus.x_pos        = org_q;
  assign bus.moving_right = dir_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = done_q;

endmodule

// File: tb/tb_car_sprite_mover.sv
// Bench for car_sprite_mover: five differently parameterised engines share
// clock and reset; a step-relative timing model predicts every output.
module tb_car_sprite_mover;

  localparam int NC = 5;
  // cfg0 defaults, cfg1 right wrap, cfg2 bounce, cfg3 wide/clipped, cfg4 left wrap
  localparam int CW [NC] = '{8, 8, 8, 16, 8};
  localparam int CH [NC] = '{4, 4, 4, 4, 4};
  localparam int XS [NC] = '{62, 127, 125, 150, 28};
  localparam int XM [NC] = '{127, 127, 127, 200, 127};
  localparam int ST [NC] = '{1, 1, 4, 1, 3};
  localparam int DR [NC] = '{1, 1, 1, 1, 0};
  localparam int BO [NC] = '{0, 0, 1, 0, 0};
  localparam int DC [NC] = '{83, 3, 3, 3, 2};
  localparam int HF [NC] = '{5, 2, 2, 2, 2};
  localparam int XMIN = 26;
  localparam int YL   = 75;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [NC-1:0] en_w;
  logic [2:0]    col_w [NC];
  logic [NC-1:0] plot_w, busy_w, done_w, mr_w;
  logic [7:0]    x_w [NC];
  logic [6:0]    y_w [NC];
  logic [2:0]    co_w [NC];
  logic [7:0]    xp_w [NC];

  for (genvar g = 0; g < NC; g++) begin : G
    car_sprite_mover_if bus();
    assign bus.en     = en_w[g];
    assign bus.colour = col_w[g];
    assign plot_w[g]  = bus.plot;
    assign busy_w[g]  = bus.busy;
    assign done_w[g]  = bus.done;
    assign mr_w[g]    = bus.moving_right;
    assign x_w[g]     = bus.x;
    assign y_w[g]     = bus.y;
    assign co_w[g]    = bus.colour_out;
    assign xp_w[g]    = bus.x_pos;

    car_sprite_mover #(
      .CAR_W(CW[g]), .CAR_H(CH[g]), .X_START(XS[g]), .Y_LANE(YL),
      .X_MIN(XMIN), .X_MAX(XM[g]), .STEP(ST[g]), .DIR_RIGHT(DR[g] != 0),
      .BOUNCE(BO[g] != 0), .DELAY_CYCLES(DC[g]), .HOLD_FRAMES(HF[g])
    ) dut (
      .clk(clk),
      .resetn(resetn),
      .bus(bus)
    );
  end

  int checks = 0;
  int failures = 0;
  int busy_cnt [NC];
  int done_cnt [NC];
  int plot_cnt [NC];

  task automatic chk(input int i, input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL cfg%0d %s at %0t: got %0d expected %0d", i, nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // t = cycles since the step was accepted (-1 when idle). A step is
  // N erase cycles, 1 move, N draw, D hold, then one idle cycle with done.
  int  t [NC], org [NC], lx [NC], ly [NC];
  bit  dir [NC], done_e [NC];

  function automatic void mreset(input int i);
    t[i] = -1; done_e[i] = 0; org[i] = XS[i]; dir[i] = (DR[i] != 0);
    lx[i] = XS[i]; ly[i] = YL;
  endfunction

  function automatic void mmove(input int i);
    if (dir[i]) begin
      if (org[i] + ST[i] <= XM[i]) org[i] += ST[i];
      else if (BO[i] == 0) org[i] = XMIN;
      else begin org[i] = XM[i]; dir[i] = 0; end
    end else begin
      if (org[i] >= XMIN + ST[i]) org[i] -= ST[i];
      else if (BO[i] == 0) org[i] = XM[i];
      else begin org[i] = XMIN; dir[i] = 1; end
    end
  endfunction

  initial begin
    for (int i = 0; i < NC; i++) begin
      mreset(i); busy_cnt[i] = 0; done_cnt[i] = 0; plot_cnt[i] = 0;
    end
    forever begin
      @(posedge clk);
      if (resetn) begin
        for (int i = 0; i < NC; i++) begin
          int n, last;
          n = CW[i] * CH[i];
          last = 2 * n + DC[i] * HF[i];
          if (t[i] < 0) begin
            done_e[i] = 0;
            if (en_w[i]) t[i] = 0;
          end else if (t[i] == last) begin
            t[i] = -1; done_e[i] = 1;
          end else begin
            if (t[i] == n) mmove(i);
            t[i]++;
          end
        end
      end
      @(negedge clk);
      for (int i = 0; i < NC; i++) begin
        int n, k, ex, ey, ep, ec;
        if (!resetn) mreset(i);
        n = CW[i] * CH[i];
        ex = lx[i]; ey = ly[i]; ep = 0; ec = 0; k = -1;
        if (t[i] >= 0 && t[i] < n) k = t[i];
        else if (t[i] > n && t[i] <= 2 * n) begin k = t[i] - n - 1; ec = col_w[i]; end
        if (k >= 0) begin
          ex = org[i] + k % CW[i];
          ey = YL + k / CW[i];
          ep = (ex < 160 && ey < 120) ? 1 : 0;
        end
        lx[i] = ex; ly[i] = ey;
        chk(i, "plot", plot_w[i], ep);
        chk(i, "x", x_w[i], ex & 255);
        chk(i, "y", y_w[i], ey);
        chk(i, "colour_out", co_w[i], ec);
        chk(i, "busy", busy_w[i], (t[i] >= 0) ? 1 : 0);
        chk(i, "done", done_w[i], (done_e[i] && t[i] < 0) ? 1 : 0);
        chk(i, "x_pos", xp_w[i], org[i]);
        chk(i, "moving_right", mr_w[i], dir[i] ? 1 : 0);
        busy_cnt[i] += busy_w[i];
        done_cnt[i] += done_w[i];
        plot_cnt[i] += plot_w[i];
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [NC-1:0] m);
    @(posedge clk); #2 en_w = m;
    @(posedge clk); #2 en_w = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (busy_w != '0 && n < 5000);
    chk(-1, "idle_timeout", int'(busy_w != '0), 0);
    repeat (2) @(negedge clk);
  endtask

  int b0 [NC], d0 [NC], p0 [NC];
  task automatic snap();
    for (int i = 0; i < NC; i++) begin
      b0[i] = busy_cnt[i]; d0[i] = done_cnt[i]; p0[i] = plot_cnt[i];
    end
  endtask

  initial begin
    int cyc, nd, first_d, last_d;
    resetn = 1'b1;
    en_w = '0;
    for (int i = 0; i < NC; i++) col_w[i] = 3'($urandom);
    #1 resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk(0, "rst_x", x_w[0], 62);
    chk(0, "rst_y", y_w[0], 75);
    chk(0, "rst_busy", busy_w[0], 0);
    chk(0, "rst_plot", plot_w[0], 0);
    @(posedge clk); #2 resetn = 1'b1;

    // single step on every engine
    snap();
    step('1);
    @(negedge clk);
    chk(0, "erase0_x", x_w[0], 62);
    chk(0, "erase0_y", y_w[0], 75);
    chk(0, "erase0_plot", plot_w[0], 1);
    wait_idle();
    chk(0, "step_xpos", xp_w[0], 63);
    chk(0, "busy_len", busy_cnt[0] - b0[0], 480);
    chk(0, "done_pulses", done_cnt[0] - d0[0], 1);
    chk(0, "plot_pixels", plot_cnt[0] - p0[0], 64);
    chk(1, "wrap_xpos", xp_w[1], 26);
    chk(2, "bounce_xpos", xp_w[2], 127);
    chk(2, "bounce_dir", mr_w[2], 0);
    chk(3, "clip_xpos", xp_w[3], 151);
    chk(3, "clip_busy_len", busy_cnt[3] - b0[3], 135);
    chk(3, "clip_plot_pixels", plot_cnt[3] - p0[3], 76);
    chk(4, "lwrap_xpos", xp_w[4], 127);
    chk(4, "lwrap_dir", mr_w[4], 0);

    step(5'b00100);
    wait_idle();
    chk(2, "bounce2_xpos", xp_w[2], 123);

    // en held high: back-to-back steps, one done per 481-cycle period
    @(posedge clk); #2 en_w[0] = 1'b1;
    cyc = 0; nd = 0; first_d = 0; last_d = 0;
    while (nd < 3 && cyc < 3000) begin
      @(negedge clk); cyc++;
      if (done_w[0]) begin
        if (nd == 0) first_d = cyc;
        last_d = cyc; nd++;
      end
    end
    chk(0, "held_dones", nd, 3);
    chk(0, "held_period2", last_d - first_d, 962);
    @(posedge clk); #2 en_w = '0;
    wait_idle();

    // reset in the middle of DRAW
    step(5'b00001);
    repeat (CW[0] * CH[0] + 5) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk(0, "midrst_plot", plot_w[0], 0);
    chk(0, "midrst_busy", busy_w[0], 0);
    chk(0, "midrst_done", done_w[0], 0);
    chk(0, "midrst_xpos", xp_w[0], 62);
    @(posedge clk); #2 resetn = 1'b1;
    step(5'b00001);
    @(negedge clk);
    chk(0, "post_rst_x", x_w[0], 62);
    chk(0, "post_rst_busy", busy_w[0], 1);
    wait_idle();

    // randomized traffic with occasional resets
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk); #2;
      for (int i = 0; i < NC; i++) begin
        en_w[i] = ($urandom_range(0, 99) < 30);
        col_w[i] = 3'($urandom);
      end
      if ($urandom_range(0, 3999) == 0) begin
        resetn = 1'b0;
        @(posedge clk); #2 resetn = 1'b1;
      end
    end
    @(posedge clk); #2 en_w = '0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
